// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the operand-2 shift sequencer: shift types, operand-2 field
// positions and controller states.
package shift_sequencer_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int OP2_REG_BIT = 4;
  localparam int OP2_ILL_BIT = 7;
  localparam int OP2_TYPE_LO = 5;
  localparam int OP2_AMT_LO  = 7;
  localparam int OP2_RS_LO   = 8;
  localparam int OP2_ROT_LO  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RS_REQ,
    ST_RS_DATA,
    ST_OUT
  } state_t;

endpackage

// File: rtl/shift_sequencer_core.sv
// Combinational ARM barrel shifter: one shift of val by amt with ARM carry-out and
// the >=32 amount rules; amt==0 passes val and cin through unless rrx is set.
module shift_core
  import shift_sequencer_pkg::*;
(
  input  logic [31:0] val,
  input  logic [7:0]  amt,
  input  logic [1:0]  shift_type,
  input  logic        cin,
  input  logic        rrx,
  output logic [31:0] result,
  output logic        carry
);

  logic [32:0] lsl_ext;
  logic [32:0] lsr_ext;
  logic [32:0] asr_ext;
  logic [31:0] ror_val;
  logic        big;
  logic        eq32;

  // The extra bit on each extended shift catches the last bit shifted out.
  assign lsl_ext = {1'b0, val} << amt[4:0];
  assign lsr_ext = {val, 1'b0} >> amt[4:0];
  assign asr_ext = $signed({val, 1'b0}) >>> amt[4:0];
  assign ror_val = 32'({val, val} >> amt[4:0]);
  assign big     = |amt[7:5];
  assign eq32    = (amt == 8'd32);

  always_comb begin
    result = val;
    carry  = cin;
    if (rrx) begin
      result = {cin, val[31:1]};
      carry  = val[0];
    end else if (amt != 8'd0) begin
      case (shift_type)
        SH_LSL: begin
          if (!big) begin
            result = lsl_ext[31:0];
            carry  = lsl_ext[32];
          end else begin
            result = '0;
            carry  = eq32 ? val[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (!big) begin
            result = lsr_ext[32:1];
            carry  = lsr_ext[0];
          end else begin
            result = '0;
            carry  = eq32 ? val[31] : 1'b0;
          end
        end
        SH_ASR: begin
          if (!big) begin
            result = asr_ext[32:1];
            carry  = asr_ext[0];
          end else begin
            result = {32{val[31]}};
            carry  = val[31];
          end
        end
        default: begin
          // A nonzero multiple of 32 leaves the value intact but still drives carry.
          if (amt[4:0] == 5'd0) begin
            result = val;
            carry  = val[31];
          end else begin
            result = ror_val;
            carry  = ror_val[31];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Operand-2 controller for the execute-stage shifter: decodes the operand-2 field,
// fetches Rs over the shared read port for register shifts, hands results to the ALU.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int RS_AMT_BITS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_imm,
  input  logic [11:0]      req_op2,
  input  logic [31:0]      req_rm,
  input  logic             req_cin,
  input  logic             flush,
  output logic             rs_rd_req,
  output logic [3:0]       rs_addr,
  input  logic             rs_rd_gnt,
  input  logic [31:0]      rs_rd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_carry,
  output logic             res_err,
  output logic [CNT_W-1:0] rs_wait_cnt
);

  state_t      state;
  state_t      state_next;
  logic [31:0] rm_q;
  logic        cin_q;
  logic [1:0]  type_q;
  logic        accept;
  logic        op_reg;
  logic        op_ill;
  logic [7:0]  rs_amt;
  logic        rs_unused;

  logic [31:0] core_val;
  logic [7:0]  core_amt;
  logic [1:0]  core_type;
  logic        core_cin;
  logic        core_rrx;
  logic [31:0] core_result;
  logic        core_carry;

  assign op_reg    = !req_imm && req_op2[OP2_REG_BIT] && !req_op2[OP2_ILL_BIT];
  assign op_ill    = !req_imm && req_op2[OP2_REG_BIT] && req_op2[OP2_ILL_BIT];
  assign rs_amt    = 8'(rs_rd_data[RS_AMT_BITS-1:0]);
  assign rs_unused = ^rs_rd_data[31:RS_AMT_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = !flush && ((state == ST_IDLE) || ((state == ST_OUT) && res_ready));
    accept     = req_valid && req_ready;
    res_valid  = (state == ST_OUT);
    rs_rd_req  = (state == ST_RS_REQ);
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (accept) state_next = op_reg ? ST_RS_REQ : ST_OUT;
        ST_RS_REQ:  if (rs_rd_gnt) state_next = ST_RS_DATA;
        ST_RS_DATA: state_next = ST_OUT;
        ST_OUT: begin
          if (res_ready) begin
            if (accept) state_next = op_reg ? ST_RS_REQ : ST_OUT;
            else        state_next = ST_IDLE;
          end
        end
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // The one shifter serves both the incoming request and the deferred register shift;
  // RS_DATA never overlaps an accept because req_ready is low there.
  always_comb begin
    core_val  = req_rm;
    core_amt  = 8'd0;
    core_type = SH_LSL;
    core_cin  = req_cin;
    core_rrx  = 1'b0;
    if (state == ST_RS_DATA) begin
      core_val  = rm_q;
      core_amt  = rs_amt;
      core_type = type_q;
      core_cin  = cin_q;
    end else if (req_imm) begin
      core_val  = {24'd0, req_op2[7:0]};
      core_amt  = {3'd0, req_op2[OP2_ROT_LO +: 4], 1'b0};
      core_type = SH_ROR;
    end else begin
      core_type = req_op2[OP2_TYPE_LO +: 2];
      core_amt  = {3'd0, req_op2[OP2_AMT_LO +: 5]};
      if (req_op2[OP2_AMT_LO +: 5] == 5'd0) begin
        if (core_type == SH_LSR || core_type == SH_ASR) core_amt = 8'd32;
        else if (core_type == SH_ROR)                   core_rrx = 1'b1;
      end
    end
  end

  shift_core u_core (
    .val        (core_val),
    .amt        (core_amt),
    .shift_type (core_type),
    .cin        (core_cin),
    .rrx        (core_rrx),
    .result     (core_result),
    .carry      (core_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_q      <= '0;
      cin_q     <= 1'b0;
      type_q    <= SH_LSL;
      rs_addr   <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_err   <= 1'b0;
    end else if (accept) begin
      rm_q   <= req_rm;
      cin_q  <= req_cin;
      type_q <= req_op2[OP2_TYPE_LO +: 2];
      if (op_reg) begin
        rs_addr <= req_op2[OP2_RS_LO +: 4];
      end else begin
        res_data  <= op_ill ? 32'd0 : core_result;
        res_carry <= op_ill ? req_cin : core_carry;
        res_err   <= op_ill;
      end
    end else if (state == ST_RS_DATA && !flush) begin
      res_data  <= core_result;
      res_carry <= core_carry;
      res_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         rs_wait_cnt <= '0;
    else if (rs_rd_req && !rs_rd_gnt && !(&rs_wait_cnt)) rs_wait_cnt <= rs_wait_cnt + 1'b1;
  end

endmodule
